// File: rtl/ucd_cfg_master_if.sv
// ----------------------------------------------------------------------------
// ucd_cfg_master_if
// Bus bundle between the configuration master and the 8-bit up/down counter
// peripheral.
//   ncs_out       chip select, active low            (master -> counter)
//   nwr_out       write strobe, active low           (master -> counter)
//   nrd_out       read strobe, active low            (master -> counter)
//   a1_out/a0_out register address                   (master -> counter)
//   bus_dout_out  write data                         (master -> bus resolver)
//   bus_oe_out    write-data drive enable            (master -> bus resolver)
//   start_out     single-clock counter start pulse   (master -> counter)
//   bus_din_in    resolved data bus value            (bus resolver -> master)
//   err_in        counter error flag                 (counter -> master)
//   ec_in         counter end-of-cycle flag          (counter -> master)
// ----------------------------------------------------------------------------
interface ucd_cfg_master_if;
    logic       ncs_out;
    logic       nwr_out;
    logic       nrd_out;
    logic       a1_out;
    logic       a0_out;
    logic [7:0] bus_dout_out;
    logic       bus_oe_out;
    logic       start_out;
    logic [7:0] bus_din_in;
    logic       err_in;
    logic       ec_in;

    modport master (
        output ncs_out, nwr_out, nrd_out, a1_out, a0_out,
               bus_dout_out, bus_oe_out, start_out,
        input  bus_din_in, err_in, ec_in
    );

    modport slave (
        input  ncs_out, nwr_out, nrd_out, a1_out, a0_out,
               bus_dout_out, bus_oe_out, start_out,
        output bus_din_in, err_in, ec_in
    );
endinterface

// File: rtl/ucd_cfg_master.sv
// ----------------------------------------------------------------------------
// ucd_cfg_master
// Host-side sequencer for the 8-bit up/down counter peripheral. Accepts one
// configuration request, checks it, writes PLR/ULR/LLR/CCR, reads them back
// and compares, pulses start, then supervises the run until end-of-cycle,
// error or timeout and reports a status code.
//   clk_in, reset_in          clock, synchronous active-high reset
//   req_in                    request (only honoured in IDLE)
//   plr_in/ulr_in/llr_in/ccr_in  configuration captured on accept
//   busy_out                  high from accept until DONE exits
//   done_out                  one-cycle completion pulse
//   status_out                00 ok, 01 readback mismatch, 10 error, 11 timeout
//   mism_addr_out             first mismatching register address
//   bus                       counter bus (ucd_cfg_master_if.master)
// All outputs are registered: each is computed from the next state.
// ----------------------------------------------------------------------------
module ucd_cfg_master #(
    parameter int STROBE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       req_in,
    input  logic [7:0] plr_in,
    input  logic [7:0] ulr_in,
    input  logic [7:0] llr_in,
    input  logic [7:0] ccr_in,
    output logic       busy_out,
    output logic       done_out,
    output logic [1:0] status_out,
    output logic [1:0] mism_addr_out,
    ucd_cfg_master_if.master bus
);

    localparam int SW = $clog2(STROBE_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD,
        S_RD_STROBE, S_RD_CMP, S_CHK_ERR, S_START, S_RUN, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_idx, w_idx_nx;
    logic [SW-1:0] r_scnt, w_scnt_nx;
    logic [TW-1:0] r_tcnt, w_tcnt_nx;
    logic [7:0]    r_val [4];
    logic [7:0]    r_sample;
    logic [1:0]    w_status_nx, w_mism_nx;
    logic          w_accept;
    logic          w_cfg_bad;
    logic          w_sel_nx, w_wr_nx, w_rd_nx;

    // r_val index: 0 PLR, 1 ULR, 2 LLR, 3 CCR (matches the register map)
    assign w_cfg_bad = (r_val[2] > r_val[1]) || (r_val[0] < r_val[2]) ||
                       (r_val[0] > r_val[1]);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_scnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_nx;
            r_scnt  <= w_scnt_nx;
            r_tcnt  <= w_tcnt_nx;
        end
    end

    // Strobe counter restarts at zero whenever a strobe state is entered,
    // so it only advances while staying in WR_STROBE / RD_STROBE.
    always_comb begin
        w_next      = r_state;
        w_idx_nx    = r_idx;
        w_scnt_nx   = '0;
        w_tcnt_nx   = r_tcnt;
        w_status_nx = status_out;
        w_mism_nx   = mism_addr_out;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_in) begin
                    w_accept    = 1'b1;
                    w_status_nx = 2'b00;
                    w_mism_nx   = 2'b00;
                    w_next      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_cfg_bad) begin
                    w_status_nx = 2'b10;
                    w_next      = S_DONE;
                end else begin
                    w_idx_nx = 2'd0;
                    w_next   = S_WR_SETUP;
                end
            end
            S_WR_SETUP: w_next = S_WR_STROBE;
            S_WR_STROBE: begin
                if (r_scnt == SW'(STROBE_CYCLES - 1)) w_next = S_WR_HOLD;
                else                                   w_scnt_nx = r_scnt + 1'b1;
            end
            S_WR_HOLD: begin
                if (r_idx != 2'd3) begin
                    w_idx_nx = r_idx + 2'd1;
                    w_next   = S_WR_SETUP;
                end else begin
                    w_idx_nx = 2'd0;
                    w_next   = S_RD_STROBE;
                end
            end
            S_RD_STROBE: begin
                // One cycle longer than the write strobe to cover bus turnaround
                if (r_scnt == SW'(STROBE_CYCLES)) w_next = S_RD_CMP;
                else                               w_scnt_nx = r_scnt + 1'b1;
            end
            S_RD_CMP: begin
                if (r_sample != r_val[r_idx]) begin
                    w_status_nx = 2'b01;
                    w_mism_nx   = r_idx;
                    w_next      = S_DONE;
                end else if (r_idx != 2'd3) begin
                    w_idx_nx = r_idx + 2'd1;
                    w_next   = S_RD_STROBE;
                end else begin
                    w_next = S_CHK_ERR;
                end
            end
            S_CHK_ERR: begin
                if (bus.err_in) begin
                    w_status_nx = 2'b10;
                    w_next      = S_DONE;
                end else begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_tcnt_nx = '0;
                w_next    = S_RUN;
            end
            S_RUN: begin
                // ec_in outranks err_in, which outranks timeout
                if (bus.ec_in) begin
                    w_status_nx = 2'b00;
                    w_next      = S_DONE;
                end else if (bus.err_in) begin
                    w_status_nx = 2'b10;
                    w_next      = S_DONE;
                end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_status_nx = 2'b11;
                    w_next      = S_DONE;
                end else begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_sel_nx = (w_next inside {S_WR_SETUP, S_WR_STROBE, S_WR_HOLD,
                                      S_RD_STROBE, S_RD_CMP, S_CHK_ERR,
                                      S_START, S_RUN});
    assign w_wr_nx  = (w_next inside {S_WR_SETUP, S_WR_STROBE, S_WR_HOLD});
    assign w_rd_nx  = (w_next == S_RD_STROBE);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            bus.ncs_out      <= 1'b1;
            bus.nwr_out      <= 1'b1;
            bus.nrd_out      <= 1'b1;
            bus.a1_out       <= 1'b0;
            bus.a0_out       <= 1'b0;
            bus.bus_dout_out <= 8'h00;
            bus.bus_oe_out   <= 1'b0;
            bus.start_out    <= 1'b0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            status_out       <= 2'b00;
            mism_addr_out    <= 2'b00;
        end else begin
            bus.ncs_out      <= ~w_sel_nx;
            bus.nwr_out      <= ~(w_next == S_WR_STROBE);
            bus.nrd_out      <= ~w_rd_nx;
            {bus.a1_out, bus.a0_out} <= (w_wr_nx || w_rd_nx) ? w_idx_nx : 2'b00;
            bus.bus_dout_out <= w_wr_nx ? r_val[w_idx_nx] : 8'h00;
            bus.bus_oe_out   <= w_wr_nx;
            bus.start_out    <= (w_next == S_START);
            busy_out         <= (w_next != S_IDLE);
            done_out         <= (w_next == S_DONE);
            status_out       <= w_status_nx;
            mism_addr_out    <= w_mism_nx;
        end
    end

    // Configuration and readback sample are plain data: no reset needed.
    // The sample is refreshed every RD_STROBE cycle, so it holds the value
    // present at the final edge of the strobe.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_val[0] <= plr_in;
            r_val[1] <= ulr_in;
            r_val[2] <= llr_in;
            r_val[3] <= ccr_in;
        end
        if (r_state == S_RD_STROBE) r_sample <= bus.bus_din_in;
    end

endmodule

// File: tb/tb_ucd_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_ucd_cfg_master
// Bench for ucd_cfg_master: a behavioural counter-peripheral model answers the
// bus, and a transaction-level reference predicts status, completion cycle
// and start cycle from the configuration and the scenario chosen.
// ----------------------------------------------------------------------------
module tb_ucd_cfg_master;

    localparam int STROBE_CYCLES  = 1;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       req_in;
    logic [7:0] plr_in, ulr_in, llr_in, ccr_in;
    logic       busy_out, done_out;
    logic [1:0] status_out, mism_addr_out;

    ucd_cfg_master_if u_bus ();

    ucd_cfg_master #(
        .STROBE_CYCLES (STROBE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .req_in       (req_in),
        .plr_in       (plr_in),
        .ulr_in       (ulr_in),
        .llr_in       (llr_in),
        .ccr_in       (ccr_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .status_out   (status_out),
        .mism_addr_out(mism_addr_out),
        .bus          (u_bus)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    endtask

    // ---------------- peripheral model ----------------
    logic [7:0] m_regs [4];
    logic [9:0] m_wr_q [$];
    int         m_nwr_cyc   = 0;
    int         m_ncs_low   = 0;
    int         m_start_cnt = 0;
    int         m_conflict  = 0;
    logic       m_nwr_prev  = 1'b1;
    bit         m_running   = 1'b0;
    int         m_run_idx   = 0;
    int         m_corrupt_idx = 4;
    logic [7:0] m_corrupt_val = 8'h00;
    bit         m_err_pre   = 1'b0;
    int         m_ec_at     = -1;
    int         m_err_at    = -1;
    logic [7:0] m_rd_data;
    logic [1:0] m_addr;

    assign m_addr = {u_bus.a1_out, u_bus.a0_out};

    always_comb begin
        m_rd_data = m_regs[m_addr];
        if (int'(m_addr) == m_corrupt_idx) m_rd_data = m_corrupt_val;
    end

    assign u_bus.bus_din_in = u_bus.bus_oe_out ? u_bus.bus_dout_out :
                              (!u_bus.nrd_out && !u_bus.ncs_out) ? m_rd_data : 8'hFF;
    assign u_bus.ec_in  = m_running && (m_run_idx == m_ec_at);
    assign u_bus.err_in = m_err_pre || (m_running && (m_run_idx == m_err_at));

    always @(posedge clk_in) begin
        if (!u_bus.ncs_out) m_ncs_low <= m_ncs_low + 1;
        if (!u_bus.ncs_out && !u_bus.nwr_out) begin
            m_nwr_cyc      <= m_nwr_cyc + 1;
            m_regs[m_addr] <= u_bus.bus_dout_out;
            if (m_nwr_prev) m_wr_q.push_back({m_addr, u_bus.bus_dout_out});
        end
        if (u_bus.bus_oe_out && !u_bus.nrd_out) m_conflict <= m_conflict + 1;
        m_nwr_prev <= u_bus.nwr_out;
        if (u_bus.start_out) begin
            m_start_cnt <= m_start_cnt + 1;
            m_running   <= 1'b1;
            m_run_idx   <= 0;
        end else if (u_bus.ncs_out) begin
            m_running <= 1'b0;
        end else if (m_running) begin
            m_run_idx <= m_run_idx + 1;
        end
    end

    // ---------------- transaction-level reference ----------------
    // Cycle 0 is the cycle in which IDLE sees req_in; cycle n is sampled at
    // the n-th falling edge after it.
    function automatic void ref_model(
        input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
        input int cidx, input bit epre, input int ec_at, input int err_at,
        output int st, output int ma, output int dcyc, output int scyc);
        int phase_len, ev;
        phase_len = 4 * (STROBE_CYCLES + 2);
        ma   = 0;
        scyc = -1;
        if (l > u || p < l || p > u) begin
            st = 2; dcyc = 2; return;
        end
        if (cidx < 4) begin
            st = 1; ma = cidx;
            dcyc = 2 + phase_len + (cidx + 1) * (STROBE_CYCLES + 2);
            return;
        end
        if (epre) begin
            st = 2; dcyc = 3 + 2 * phase_len; return;
        end
        scyc = 3 + 2 * phase_len;
        ev = TIMEOUT_CYCLES - 1;
        st = 3;
        if (err_at >= 0 && err_at <= ev) begin ev = err_at; st = 2; end
        if (ec_at  >= 0 && ec_at  <= ev) begin ev = ec_at;  st = 0; end
        dcyc = scyc + 2 + ev;
    endfunction

    task automatic run_txn(
        input logic [7:0] p, input logic [7:0] u, input logic [7:0] l, input logic [7:0] c,
        input int cidx, input logic [7:0] cval, input bit epre,
        input int ec_at, input int err_at, input int ghost);
        int st, ma, dcyc, scyc;
        int wr_base, nwr_base, ncs_base, start_base;
        int obs_done, obs_start;
        logic [1:0] obs_st, obs_ma;
        logic [7:0] v [4];
        v = '{p, u, l, c};
        ref_model(p, u, l, cidx, epre, ec_at, err_at, st, ma, dcyc, scyc);

        @(negedge clk_in);
        m_corrupt_idx = cidx;
        m_corrupt_val = cval;
        m_err_pre     = epre;
        m_ec_at       = ec_at;
        m_err_at      = err_at;
        wr_base    = m_wr_q.size();
        nwr_base   = m_nwr_cyc;
        ncs_base   = m_ncs_low;
        start_base = m_start_cnt;
        plr_in = p; ulr_in = u; llr_in = l; ccr_in = c;
        req_in = 1'b1;
        obs_done  = -1;
        obs_start = -1;
        obs_st    = 2'b00;
        obs_ma    = 2'b00;
        @(negedge clk_in);
        for (int cyc = 1; cyc <= 100; cyc++) begin
            req_in = (cyc == ghost);
            if (cyc == 1) begin
                chk("busy_after_accept", busy_out, 1'b1);
                chk("status_clear_on_accept", status_out, 2'b00);
            end
            if (u_bus.start_out && obs_start < 0) obs_start = cyc;
            if (done_out) begin
                obs_done = cyc;
                obs_st   = status_out;
                obs_ma   = mism_addr_out;
                break;
            end
            @(negedge clk_in);
        end
        req_in = 1'b0;

        chk("done_cycle", obs_done, dcyc);
        chk("status", obs_st, st[1:0]);
        if (st == 1) chk("mism_addr", obs_ma, ma[1:0]);
        chk("start_cycle", obs_start, scyc);
        chk("start_pulses", m_start_cnt - start_base, (scyc >= 0) ? 1 : 0);
        if (st == 2 && dcyc == 2) begin
            chk("ncs_never_low", m_ncs_low - ncs_base, 0);
        end else begin
            chk("write_count", m_wr_q.size() - wr_base, 4);
            chk("nwr_low_cycles", m_nwr_cyc - nwr_base, 4 * STROBE_CYCLES);
            for (int i = 0; i < 4; i++)
                if (m_wr_q.size() > wr_base + i)
                    chk($sformatf("write%0d", i), m_wr_q[wr_base + i], {2'(i), v[i]});
        end
        @(negedge clk_in);
        chk("ncs_after_done", u_bus.ncs_out, 1'b1);
        chk("busy_after_done", busy_out, 1'b0);
        chk("done_is_pulse", done_out, 1'b0);
        chk("status_held", status_out, st[1:0]);
        m_err_pre     = 1'b0;
        m_ec_at       = -1;
        m_err_at      = -1;
        m_corrupt_idx = 4;
    endtask

    task automatic reset_mid_write();
        int dones;
        @(negedge clk_in);
        plr_in = 8'd5; ulr_in = 8'd10; llr_in = 8'd2; ccr_in = 8'd2;
        req_in = 1'b1;
        @(negedge clk_in);
        req_in = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("ulr_strobe_nwr", u_bus.nwr_out, 1'b0);
        chk("ulr_strobe_addr", {u_bus.a1_out, u_bus.a0_out}, 2'b01);
        reset_in = 1'b1;
        @(negedge clk_in);
        chk("rst_ncs", u_bus.ncs_out, 1'b1);
        chk("rst_nwr", u_bus.nwr_out, 1'b1);
        chk("rst_oe", u_bus.bus_oe_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        reset_in = 1'b0;
        dones = 0;
        repeat (40) begin
            if (done_out) dones++;
            @(negedge clk_in);
        end
        chk("no_done_after_abort", dones, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_in = 1'b1;
        req_in   = 1'b0;
        plr_in = 8'h00; ulr_in = 8'h00; llr_in = 8'h00; ccr_in = 8'h00;
        repeat (3) @(negedge clk_in);
        chk("reset_ncs", u_bus.ncs_out, 1'b1);
        chk("reset_nwr_nrd", {u_bus.nwr_out, u_bus.nrd_out}, 2'b11);
        chk("reset_start_oe", {u_bus.start_out, u_bus.bus_oe_out}, 2'b00);
        chk("reset_busy_done", {busy_out, done_out}, 2'b00);
        chk("reset_dout_addr", {u_bus.bus_dout_out, u_bus.a1_out, u_bus.a0_out}, 10'd0);
        chk("reset_status_mism", {status_out, mism_addr_out}, 4'd0);
        reset_in = 1'b0;

        // Directed scenarios (args: p u l c, corrupt idx/val, err_pre, ec_at, err_at, ghost req cycle)
        run_txn(8'd5, 8'd10, 8'd2, 8'd2, 4, 8'h00, 1'b0, 2, -1, 10);
        run_txn(8'd1, 8'd9,  8'd4, 8'd3, 4, 8'h00, 1'b0, 2, -1, 0);
        run_txn(8'd5, 8'd10, 8'd2, 8'd2, 2, 8'h03, 1'b0, 2, -1, 0);
        run_txn(8'd5, 8'd10, 8'd2, 8'd2, 4, 8'h00, 1'b0, -1, -1, 0);
        run_txn(8'd5, 8'd10, 8'd2, 8'd2, 4, 8'h00, 1'b0, -1, 3, 0);
        run_txn(8'd5, 8'd10, 8'd2, 8'd2, 4, 8'h00, 1'b0, 4, 4, 0);
        run_txn(8'd5, 8'd10, 8'd2, 8'd2, 4, 8'h00, 1'b1, -1, -1, 0);
        run_txn(8'd7, 8'd7,  8'd7, 8'd0, 4, 8'h00, 1'b0, 0, -1, 0);
        reset_mid_write();
        run_txn(8'd5, 8'd10, 8'd2, 8'd2, 4, 8'h00, 1'b0, 1, -1, 0);

        // Randomised scenarios
        for (int t = 0; t < 40; t++) begin
            logic [7:0] p, u, l, c, cval;
            int cidx, ec_at, err_at, kind;
            bit epre;
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                p = 8'($urandom_range(0, 255));
                u = 8'($urandom_range(0, 255));
                l = 8'($urandom_range(0, 255));
            end else begin
                l = 8'($urandom_range(0, 255));
                u = 8'($urandom_range(int'(l), 255));
                p = 8'($urandom_range(int'(l), int'(u)));
            end
            cidx = 4; cval = 8'h00; epre = 1'b0; ec_at = -1; err_at = -1;
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    cidx = $urandom_range(0, 3);
                    case (cidx)
                        0: cval = p; 1: cval = u; 2: cval = l; default: cval = c;
                    endcase
                    cval = cval ^ (8'd1 << $urandom_range(0, 7));
                end
                1: epre = 1'b1;
                2: ec_at = $urandom_range(0, 20);
                3: err_at = $urandom_range(0, 20);
                4: begin ec_at = $urandom_range(0, 15); err_at = ec_at; end
                default: ;
            endcase
            run_txn(p, u, l, c, cidx, cval, epre, ec_at, err_at, (kind == 2) ? 8 : 0);
        end

        chk("oe_during_read", m_conflict, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
